id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 75 +++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, flush squash and a saturating bubble counter.
module id_ex_stage #(
  parameter logic [15:0] STALL_MAX = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IF_ID_rs1,
  input  logic [4:0]  IF_ID_rs2,
  input  logic [4:0]  IF_ID_rd,
  input  logic [63:0] IF_ID_PC,
  input  logic [63:0] ReadData1,
  input  logic [63:0] ReadData2,
  input  logic [63:0] imm_data,
  input  logic [3:0]  funct4,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        Branch,
  input  logic        ALUSrc,
  input  logic [1:0]  ALUOp,
  input  logic        flush,
  output logic [4:0]  ID_EX_rs1,
  output logic [4:0]  ID_EX_rs2,
  output logic [4:0]  ID_EX_rd,
  output logic [63:0] ID_EX_PC,
  output logic [63:0] ID_EX_ReadData1,
  output logic [63:0] ID_EX_ReadData2,
  output logic [63:0] ID_EX_imm_data,
  output logic [3:0]  ID_EX_funct4,
  output logic        ID_EX_RegWrite,
  output logic        ID_EX_MemRead,
  output logic        ID_EX_MemWrite,
  output logic        ID_EX_MemtoReg,
  output logic        ID_EX_Branch,
  output logic        ID_EX_ALUSrc,
  output logic [1:0]  ID_EX_ALUOp,
  output logic        ID_EX_valid,
  output logic        hazard,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic [15:0] stall_count
);
  logic w_hazard;
  logic w_clear;
  // flush squashes the dependent instruction, so it also masks the stall
  assign w_hazard = ID_EX_valid & ID_EX_MemRead & (ID_EX_rd != 5'd0) &
                    ((ID_EX_rd == IF_ID_rs1) | (ID_EX_rd == IF_ID_rs2)) & ~flush;
  assign w_clear     = reset | flush | w_hazard;
  assign hazard      = w_hazard;
  assign PCWrite     = ~w_hazard;
  assign IF_ID_Write = ~w_hazard;
  always_ff @(posedge clk) begin
    ID_EX_rs1       <= w_clear ? 5'd0  : IF_ID_rs1;
    ID_EX_rs2       <= w_clear ? 5'd0  : IF_ID_rs2;
    ID_EX_rd        <= w_clear ? 5'd0  : IF_ID_rd;
    ID_EX_PC        <= w_clear ? 64'd0 : IF_ID_PC;
    ID_EX_ReadData1 <= w_clear ? 64'd0 : ReadData1;
    ID_EX_ReadData2 <= w_clear ? 64'd0 : ReadData2;
    ID_EX_imm_data  <= w_clear ? 64'd0 : imm_data;
    ID_EX_funct4    <= w_clear ? 4'd0  : funct4;
    ID_EX_RegWrite  <= ~w_clear & RegWrite;
    ID_EX_MemRead   <= ~w_clear & MemRead;
    ID_EX_MemWrite  <= ~w_clear & MemWrite;
    ID_EX_MemtoReg  <= ~w_clear & MemtoReg;
    ID_EX_Branch    <= ~w_clear & Branch;
    ID_EX_ALUSrc    <= ~w_clear & ALUSrc;
    ID_EX_ALUOp     <= w_clear ? 2'd0 : ALUOp;
    ID_EX_valid     <= ~w_clear;
    if (reset)
      stall_count <= 16'd0;
    else if (w_hazard && stall_count != STALL_MAX)
      stall_count <= stall_count + 16'd1;
  end
endmodule
